fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter IMEM_WAIT_MAX, default 15: maximum cycles FETCH waits for imem_ack before faulting.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins execution from IDLE.
REQ-005 imem_ack  input  1  instruction memory has valid data on instr this cycle.
REQ-006 instr  input  16  instruction word from instruction memory.
REQ-007 zero_flag  input  1  ALU zero flag, sampled in DECODE.
REQ-008 ex_ack  input  1  execute unit completion for the current non-branch instruction.
REQ-009 imem_req  output  1  fetch request to instruction memory at the current PC.
REQ-010 ir  output  16  instruction register.
REQ-011 ex_req  output  1  execute request to the datapath.
REQ-012 pc_en  output  1  program counter update enable.
REQ-013 pc_ctrl  output  2  00 hold, 01 increment, 10 absolute load {8'h00,offset}, 11 add offset.
REQ-014 offset_addr  output  8  jump target or offset, always ir[7:0].
REQ-015 halted  output  1  controller has stopped.
REQ-016 err  output  1  fetch timeout occurred.

Function
REQ-017 Opcode is ir[15:12]: 0x0 NOP, 0xC JMP, 0xD JZ, 0xE JNZ, 0xF HALT; every other opcode is an EXEC-class instruction.
REQ-018 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, UPDATE, and HALT.
REQ-019 IDLE: all outputs 0; start=1 -> FETCH on the next cycle.
REQ-020 FETCH: imem_req=1 while in the state; on imem_ack=1, ir<=instr and -> DECODE.
REQ-021 FETCH wait counter SHALL start at 0 on entry and increment each cycle without ack; if it reaches IMEM_WAIT_MAX without ack -> HALT with err=1, and ir is unchanged.
REQ-022 imem_ack arriving in the same cycle the counter reaches IMEM_WAIT_MAX SHALL take priority (normal fetch, no err).
REQ-023 DECODE, one cycle: NOP -> UPDATE with pc_ctrl=01; JMP -> UPDATE with pc_ctrl=10.
REQ-024 DECODE: JZ -> UPDATE with pc_ctrl=11 if zero_flag=1, else pc_ctrl=01.
REQ-025 DECODE: JNZ -> UPDATE with pc_ctrl=11 if zero_flag=0, else pc_ctrl=01.
REQ-026 DECODE: HALT -> HALT state and the PC is not updated; EXEC-class -> EXEC.
REQ-027 EXEC: ex_req=1 until ex_ack=1; on ack -> UPDATE with pc_ctrl=01. EXEC has no timeout.
REQ-028 UPDATE: pc_en=1 for exactly one cycle with pc_ctrl valid in that same cycle; -> FETCH.
REQ-029 pc_en SHALL be 0 in every state except UPDATE.
REQ-030 pc_ctrl and offset_addr are registered and change only on DECODE/EXEC exit; pc_ctrl returns to 00 after UPDATE.
REQ-031 Each instruction produces exactly one pc_en pulse; HALT and a fetch timeout produce none.
REQ-032 HALT: halted=1 and all request outputs 0; the controller remains in HALT until rst, and start is ignored there.
REQ-033 start asserted in any state other than IDLE SHALL be ignored.
REQ-034 Minimum latency for NOP/JMP/JZ/JNZ: ack cycle -> DECODE -> UPDATE, i.e. pc_en asserted 2 cycles after the imem_ack edge.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and set ir=0, pc_ctrl=00, offset_addr=0, all 1-bit outputs=0, and wait counter=0.
REQ-036 rst asserted mid-FETCH, mid-EXEC, or in UPDATE SHALL abort with no pc_en pulse after reset assertion; after release, the block waits for start.

Verification
REQ-037 Sequential fetch: start, instr=0x0000 acked immediately -> imem_req 1 cycle, pc_en=1 with pc_ctrl=01 exactly 2 cycles after ack, then imem_req again.
REQ-038 Absolute jump: instr=0xC042 -> UPDATE cycle with pc_ctrl=10 and offset_addr=0x42, and ir=0xC042.
REQ-039 Conditional branch: instr=0xD005 with zero_flag=1 -> pc_ctrl=11, offset 0x05; repeat with zero_flag=0 -> pc_ctrl=01; instr=0xE005 with zero_flag=0 -> pc_ctrl=11.
REQ-040 Execute handshake: instr=0x1234, ex_ack delayed 5 cycles -> ex_req high 6 cycles, then a single pc_en with pc_ctrl=01.
REQ-041 Halt and timeout: instr=0xF000 -> halted=1, no pc_en, and later start ignored; separately, no imem_ack for 15 cycles -> halted=1 and err=1.
REQ-042 Reset mid-EXEC: assert rst while ex_req=1 -> all outputs 0 asynchronously, state IDLE, and no pc_en until a new start and fetch.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode sequencer: fetches a word, decodes flow-control opcodes,
// hands other work to the execute unit and issues one PC update per instruction.
module fetch_ctrl #(
  parameter int unsigned IMEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        imem_ack,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  input  logic        ex_ack,
  output logic        imem_req,
  output logic [15:0] ir,
  output logic        ex_req,
  output logic        pc_en,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic        halted,
  output logic        err
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OFFS_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned CNT_W   = (IMEM_WAIT_MAX < 2) ? 1 : $clog2(IMEM_WAIT_MAX);

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hD;
  localparam logic [OP_W-1:0] OP_JNZ  = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_ADD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [OFFS_W-1:0]   offset_addr_q;
  logic [1:0]          pc_ctrl_q;
  logic                imem_req_q;
  logic                ex_req_q;
  logic                pc_en_q;
  logic                halted_q;
  logic                err_q;

  logic [OP_W-1:0]     opcode_c;
  logic [1:0]          decode_pc_ctrl_c;
  logic                is_exec_c;
  logic                fetch_timeout_c;

  assign opcode_c        = ir_q[INSTR_W-1 -: OP_W];
  assign fetch_timeout_c = (wait_cnt_q == CNT_W'(IMEM_WAIT_MAX - 1));

  // PC action for flow-control opcodes; conditional branches resolve on zero_flag here
  always_comb begin
    decode_pc_ctrl_c = PC_INC;
    is_exec_c        = 1'b0;
    case (opcode_c)
      OP_NOP:  decode_pc_ctrl_c = PC_INC;
      OP_JMP:  decode_pc_ctrl_c = PC_LOAD;
      OP_JZ:   decode_pc_ctrl_c = zero_flag ? PC_ADD : PC_INC;
      OP_JNZ:  decode_pc_ctrl_c = zero_flag ? PC_INC : PC_ADD;
      OP_HALT: decode_pc_ctrl_c = PC_HOLD;
      default: is_exec_c = 1'b1;
    endcase
  end

  // Outputs are registered alongside the state so each reflects the state it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      ir_q          <= '0;
      offset_addr_q <= '0;
      pc_ctrl_q     <= PC_HOLD;
      imem_req_q    <= 1'b0;
      ex_req_q      <= 1'b0;
      pc_en_q       <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pc_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
            wait_cnt_q <= '0;
          end
        end
        S_FETCH: begin
          // A late ack still wins over the timeout on the final wait cycle
          if (imem_ack) begin
            ir_q       <= instr;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (fetch_timeout_c) begin
            imem_req_q <= 1'b0;
            halted_q   <= 1'b1;
            err_q      <= 1'b1;
            state_q    <= S_HALT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          offset_addr_q <= ir_q[OFFS_W-1:0];
          if (opcode_c == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (is_exec_c) begin
            ex_req_q <= 1'b1;
            state_q  <= S_EXEC;
          end else begin
            pc_en_q   <= 1'b1;
            pc_ctrl_q <= decode_pc_ctrl_c;
            state_q   <= S_UPDATE;
          end
        end
        S_EXEC: begin
          if (ex_ack) begin
            ex_req_q  <= 1'b0;
            pc_en_q   <= 1'b1;
            pc_ctrl_q <= PC_INC;
            state_q   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          pc_ctrl_q  <= PC_HOLD;
          imem_req_q <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign ir          = ir_q;
  assign ex_req      = ex_req_q;
  assign pc_en       = pc_en_q;
  assign pc_ctrl     = pc_ctrl_q;
  assign offset_addr = offset_addr_q;
  assign halted      = halted_q;
  assign err         = err_q;

  // Request strobes must track their owning state exactly
  a_pc_en_update: assert property (@(posedge clk) disable iff (rst)
    pc_en_q |-> (state_q == S_UPDATE));
  a_ex_req_exec: assert property (@(posedge clk) disable iff (rst)
    ex_req_q == (state_q == S_EXEC));
  a_imem_req_fetch: assert property (@(posedge clk) disable iff (rst)
    imem_req_q == (state_q == S_FETCH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-instruction observations are compared
// against a transaction-level model of the controller's behaviour.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] instr = '0;
  logic        zero_flag = 1'b0;
  logic        ex_ack = 1'b0;
  logic        imem_req;
  logic [15:0] ir;
  logic        ex_req;
  logic        pc_en;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;
  logic        halted;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.IMEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_ack(imem_ack), .instr(instr),
    .zero_flag(zero_flag), .ex_ack(ex_ack), .imem_req(imem_req), .ir(ir),
    .ex_req(ex_req), .pc_en(pc_en), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pulses;
    logic [1:0]  ctrl;
    logic [7:0]  off;
    int          lat;
    int          fetch_n;
    int          ex_n;
    logic [15:0] ir_v;
    logic        halted_v;
    logic        err_v;
    logic [1:0]  ctrl_after;
    bit          to;
  } obs_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; ex_ack = 1'b0; zero_flag = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Expected outcome of one instruction: kind 0 = flow/PC update, 1 = execute, 2 = halt
  function automatic void ref_model(input logic [15:0] ins, input logic zf, input int ex_dly,
                                    output int kind, output logic [1:0] ctrl, output int lat);
    kind = 0; ctrl = 2'b01;
    case (ins[15:12])
      4'h0: ctrl = 2'b01;
      4'hC: ctrl = 2'b10;
      4'hD: ctrl = zf ? 2'b11 : 2'b01;
      4'hE: ctrl = zf ? 2'b01 : 2'b11;
      4'hF: begin kind = 2; ctrl = 2'b00; end
      default: kind = 1;
    endcase
    lat = (kind == 0) ? 2 : (kind == 1) ? ex_dly + 3 : -1;
  endfunction

  // Runs one instruction starting in a FETCH cycle; stops at the next FETCH or at halt
  task automatic do_instr(input logic [15:0] ins, input logic zf, input int ack_dly,
                          input int ex_dly, input bit noise, output obs_t o);
    int fetch_cnt, ex_cnt, ack_c;
    bit acked;
    o.pulses = 0; o.ctrl = '0; o.off = '0; o.lat = -1; o.fetch_n = 0; o.ex_n = 0;
    o.ir_v = '0; o.halted_v = 1'b0; o.err_v = 1'b0; o.ctrl_after = '0; o.to = 1'b1;
    fetch_cnt = 0; ex_cnt = 0; ack_c = -1; acked = 1'b0;
    zero_flag = zf;
    for (int c = 0; c < 80; c++) begin
      if (c > 0 && ((o.pulses > 0 && imem_req) || halted)) begin
        o.to = 1'b0; o.ctrl_after = pc_ctrl; o.halted_v = halted; o.err_v = err;
        break;
      end
      if (pc_en) begin
        o.pulses++; o.ctrl = pc_ctrl; o.off = offset_addr; o.lat = c - ack_c;
      end
      if (acked && c == ack_c + 1) o.ir_v = ir;
      if (ex_req) o.ex_n++;
      imem_ack = 1'b0;
      instr = 16'($urandom);
      if (imem_req && !acked) begin
        if (fetch_cnt == ack_dly) begin
          imem_ack = 1'b1; instr = ins; acked = 1'b1; ack_c = c;
        end
        fetch_cnt++;
      end
      ex_ack = ex_req && (ex_cnt == ex_dly);
      if (ex_req) ex_cnt++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
    end
    o.fetch_n = fetch_cnt;
    imem_ack = 1'b0; ex_ack = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    cyc();
    n_checks++;
    if ({imem_req, ex_req, pc_en, halted, err, pc_ctrl, offset_addr, ir} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b ex=%b en=%b h=%b e=%b ctrl=%b off=%h ir=%h want all 0",
               imem_req, ex_req, pc_en, halted, err, pc_ctrl, offset_addr, ir);
    end
    start = 1'b0;
    rst = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++;
    if ({imem_req, ex_req, pc_en, halted} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle_wait: got req=%b ex=%b en=%b h=%b want 0", imem_req, ex_req, pc_en, halted);
    end
  endtask

  task automatic test_sequential();
    obs_t o;
    do_reset();
    pulse_start();
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req_after_start: got %b want 1", imem_req); end
    do_instr(16'h0000, 1'b0, 0, 0, 1'b0, o);
    n_checks++;
    if (o.to) begin n_fail++; $display("FAIL seq_timeout: got no completion want completion"); end
    n_checks++;
    if (o.fetch_n !== 1) begin n_fail++; $display("FAIL seq_req_cycles: got %0d want 1", o.fetch_n); end
    n_checks++;
    if (o.pulses !== 1 || o.ctrl !== 2'b01) begin
      n_fail++; $display("FAIL seq_pc_update: got pulses=%0d ctrl=%b want 1/01", o.pulses, o.ctrl);
    end
    n_checks++;
    if (o.lat !== 2) begin n_fail++; $display("FAIL seq_latency: got %0d want 2", o.lat); end
    n_checks++;
    if (o.ctrl_after !== 2'b00) begin n_fail++; $display("FAIL seq_ctrl_return: got %b want 00", o.ctrl_after); end
  endtask

  task automatic test_flow();
    obs_t o;
    logic [15:0] ins_t [5] = '{16'hC042, 16'hD005, 16'hD005, 16'hE005, 16'hE005};
    logic        zf_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  ctl_t [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01};
    for (int i = 0; i < 5; i++) begin
      do_instr(ins_t[i], zf_t[i], i, 0, 1'b0, o);
      n_checks++;
      if (o.to || o.pulses !== 1 || o.ctrl !== ctl_t[i]) begin
        n_fail++;
        $display("FAIL flow_ctrl[%0d]: got to=%0d pulses=%0d ctrl=%b want 0/1/%b", i, o.to, o.pulses, o.ctrl, ctl_t[i]);
      end
      n_checks++;
      if (o.off !== ins_t[i][7:0] || o.ir_v !== ins_t[i]) begin
        n_fail++;
        $display("FAIL flow_offset[%0d]: got off=%h ir=%h want %h/%h", i, o.off, o.ir_v, ins_t[i][7:0], ins_t[i]);
      end
    end
  endtask

  task automatic test_exec();
    obs_t o;
    do_instr(16'h1234, 1'b0, 0, 5, 1'b0, o);
    n_checks++;
    if (o.to || o.ex_n !== 6) begin n_fail++; $display("FAIL exec_req_cycles: got to=%0d n=%0d want 6", o.to, o.ex_n); end
    n_checks++;
    if (o.pulses !== 1 || o.ctrl !== 2'b01 || o.lat !== 8) begin
      n_fail++; $display("FAIL exec_update: got pulses=%0d ctrl=%b lat=%0d want 1/01/8", o.pulses, o.ctrl, o.lat);
    end
  endtask

  task automatic test_ack_boundary();
    obs_t o;
    do_instr(16'h0011, 1'b0, 14, 0, 1'b0, o);
    n_checks++;
    if (o.to || o.pulses !== 1 || o.fetch_n !== 15 || err !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_last_cycle: got to=%0d pulses=%0d fetch=%0d err=%b halted=%b want 0/1/15/0/0",
               o.to, o.pulses, o.fetch_n, err, halted);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int kind, lat, ack_dly, ex_dly;
    logic [1:0] ctrl;
    logic [15:0] ins;
    logic zf;
    for (int i = 0; i < 40; i++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      zf = 1'($urandom_range(0, 1));
      ack_dly = $urandom_range(0, 14);
      ex_dly = $urandom_range(0, 6);
      ref_model(ins, zf, ex_dly, kind, ctrl, lat);
      do_instr(ins, zf, ack_dly, ex_dly, 1'b1, o);
      n_checks++;
      if (o.to || o.pulses !== 1 || o.ctrl !== ctrl || o.lat !== lat) begin
        n_fail++;
        $display("FAIL rand_update[%0d] ins=%h zf=%b: got to=%0d pulses=%0d ctrl=%b lat=%0d want 0/1/%b/%0d",
                 i, ins, zf, o.to, o.pulses, o.ctrl, o.lat, ctrl, lat);
      end
      n_checks++;
      if (o.ex_n !== ((kind == 1) ? ex_dly + 1 : 0) || o.fetch_n !== ack_dly + 1) begin
        n_fail++;
        $display("FAIL rand_handshake[%0d] ins=%h: got ex=%0d fetch=%0d want %0d/%0d",
                 i, ins, o.ex_n, o.fetch_n, (kind == 1) ? ex_dly + 1 : 0, ack_dly + 1);
      end
      n_checks++;
      if (o.ir_v !== ins || o.off !== ins[7:0] || o.ctrl_after !== 2'b00 || o.err_v !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: got ir=%h off=%h after=%b err=%b want %h/%h/00/0",
                 i, o.ir_v, o.off, o.ctrl_after, o.err_v, ins, ins[7:0]);
      end
    end
  endtask

  task automatic test_halt();
    obs_t o;
    do_instr(16'hF000, 1'b0, 2, 0, 1'b0, o);
    n_checks++;
    if (o.to || o.halted_v !== 1'b1 || o.err_v !== 1'b0 || o.pulses !== 0 || o.ex_n !== 0) begin
      n_fail++;
      $display("FAIL halt_entry: got to=%0d halted=%b err=%b pulses=%0d ex=%0d want 0/1/0/0/0",
               o.to, o.halted_v, o.err_v, o.pulses, o.ex_n);
    end
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1));
      imem_ack = 1'b1;
      cyc();
      n_checks++;
      if (halted !== 1'b1 || {imem_req, ex_req, pc_en} !== 3'b0) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d]: got halted=%b req=%b ex=%b en=%b want 1/0/0/0", i, halted, imem_req, ex_req, pc_en);
      end
    end
    start = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    obs_t o;
    do_reset();
    pulse_start();
    do_instr(16'h0ABC, 1'b0, 0, 0, 1'b0, o);
    do_instr(16'h1111, 1'b0, 99, 0, 1'b0, o);
    n_checks++;
    if (o.to || o.fetch_n !== 15) begin n_fail++; $display("FAIL timeout_wait: got to=%0d cycles=%0d want 0/15", o.to, o.fetch_n); end
    n_checks++;
    if (o.halted_v !== 1'b1 || o.err_v !== 1'b1 || o.pulses !== 0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: got halted=%b err=%b pulses=%0d req=%b want 1/1/0/0", o.halted_v, o.err_v, o.pulses, imem_req);
    end
    n_checks++;
    if (ir !== 16'h0ABC) begin n_fail++; $display("FAIL timeout_ir: got %h want 0abc", ir); end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    int w;
    do_reset();
    pulse_start();
    imem_ack = 1'b1; instr = 16'h1234;
    cyc();
    imem_ack = 1'b0;
    w = 0;
    while (ex_req !== 1'b1 && w < 5) begin cyc(); w++; end
    n_checks++;
    if (ex_req !== 1'b1) begin n_fail++; $display("FAIL abort_reach_exec: got ex_req=%b want 1", ex_req); end
    ex_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, ex_req, pc_en, halted, err, pc_ctrl, offset_addr, ir} !== '0) begin
      n_fail++;
      $display("FAIL abort_exec_async: got req=%b ex=%b en=%b ctrl=%b off=%h ir=%h want all 0",
               imem_req, ex_req, pc_en, pc_ctrl, offset_addr, ir);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if ({imem_req, ex_req, pc_en} !== 3'b0) begin
        n_fail++; $display("FAIL abort_exec_idle[%0d]: got req=%b ex=%b en=%b want 0", i, imem_req, ex_req, pc_en);
      end
    end
    ex_ack = 1'b0;
    pulse_start();
    imem_ack = 1'b1; instr = 16'h0000;
    cyc();
    imem_ack = 1'b0;
    cyc();
    n_checks++;
    if (pc_en !== 1'b1) begin n_fail++; $display("FAIL abort_update_setup: got pc_en=%b want 1", pc_en); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pc_en !== 1'b0 || pc_ctrl !== 2'b00) begin
      n_fail++; $display("FAIL abort_update_async: got en=%b ctrl=%b want 0/00", pc_en, pc_ctrl);
    end
    cyc();
    rst = 1'b0;
    pulse_start();
    do_instr(16'hC033, 1'b0, 1, 0, 1'b0, o);
    n_checks++;
    if (o.to || o.pulses !== 1 || o.ctrl !== 2'b10 || o.off !== 8'h33) begin
      n_fail++; $display("FAIL abort_restart: got to=%0d pulses=%0d ctrl=%b off=%h want 0/1/10/33", o.to, o.pulses, o.ctrl, o.off);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_flow();
    test_exec();
    test_ack_boundary();
    test_random();
    test_halt();
    test_timeout();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
